// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate self-tester.
//   gate_state_t : tester FSM state encoding
//   NUM_VECTORS  : number of input vectors applied to a 2-input gate
package gate_test_pkg;

  localparam int NUM_VECTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } gate_state_t;

endpackage : gate_test_pkg

// File: rtl/settle_timer.sv
// Settle timer: counts cycles a stimulus vector has been held.
// Ports:
//   i_Clk, i_Rst : clock, async active-high reset
//   i_Clear      : synchronous clear to zero (has priority over enable)
//   i_Enable     : count up by one this cycle
//   o_Tc         : high while the count equals SETTLE_CYCLES-1
module settle_timer #(
  parameter int SETTLE_CYCLES = 10
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Tc
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] count;

  // Counting stops at the terminal value so the counter can never wrap,
  // even if enable is held past terminal count.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count <= '0;
    end else if (i_Clear) begin
      count <= '0;
    end else if (i_Enable && (count != TC_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign o_Tc = (count == TC_VAL);

endmodule : settle_timer

// File: rtl/gate_self_tester.sv
// Exhaustive self-tester for a 2-input combinational gate. Applies the four
// input vectors in order, waits SETTLE_CYCLES for each, compares the gate
// response with the EXPECTED truth table and reports a verdict.
// Ports:
//   i_Clk, i_Rst        : clock, async active-high reset
//   i_Start             : start request (accepted only in IDLE or DONE)
//   i_Result            : response of the gate under test
//   o_Stim_1, o_Stim_2  : gate inputs (vector index bit 1 / bit 0)
//   o_Busy              : sequence running
//   o_Done              : sequence complete, verdict valid
//   o_Pass, o_Fail      : verdict
//   o_Fail_Vector       : index of first mismatching vector (0 if none)
//   o_Error_Count       : number of mismatching vectors
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start, stim held at 00
// ST_SETTLE | current vector applied, waiting for the gate to settle
// ST_CHECK  | single cycle: compare i_Result with EXPECTED[index]
// ST_DONE   | verdict held, stim at 00, waiting for restart
module gate_self_tester
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 10,
  parameter logic [3:0] EXPECTED      = 4'b1000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Result,
  output logic       o_Stim_1,
  output logic       o_Stim_2,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Pass,
  output logic       o_Fail,
  output logic [1:0] o_Fail_Vector,
  output logic [2:0] o_Error_Count
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

  gate_state_t state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [2:0]  err_nxt;
  logic [1:0]  fail_vec_nxt;
  logic        busy_nxt, done_nxt;
  logic [1:0]  stim_nxt;
  logic        timer_clear, timer_en, timer_tc;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Clear (timer_clear),
    .i_Enable(timer_en),
    .o_Tc    (timer_tc)
  );

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    err_nxt      = o_Error_Count;
    fail_vec_nxt = o_Fail_Vector;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_Start) begin
          state_nxt    = ST_SETTLE;
          idx_nxt      = 2'd0;
          err_nxt      = 3'd0;
          fail_vec_nxt = 2'd0;
          timer_clear  = 1'b1;
        end
      end
      ST_SETTLE: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        timer_clear = 1'b1;
        if (i_Result != EXPECTED[idx]) begin
          err_nxt = o_Error_Count + 3'd1;
          // Only the first mismatch of a run records its vector.
          if (o_Error_Count == 3'd0) begin
            fail_vec_nxt = idx;
          end
        end
        if (idx == LAST_IDX) begin
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = ST_SETTLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are derived from the next state so they can be registered
    // and still line up with the state they describe.
    busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
    done_nxt = (state_nxt == ST_DONE);
    stim_nxt = busy_nxt ? idx_nxt : 2'b00;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= ST_IDLE;
      idx           <= 2'd0;
      o_Stim_1      <= 1'b0;
      o_Stim_2      <= 1'b0;
      o_Busy        <= 1'b0;
      o_Done        <= 1'b0;
      o_Pass        <= 1'b0;
      o_Fail        <= 1'b0;
      o_Fail_Vector <= 2'd0;
      o_Error_Count <= 3'd0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      o_Stim_1      <= stim_nxt[1];
      o_Stim_2      <= stim_nxt[0];
      o_Busy        <= busy_nxt;
      o_Done        <= done_nxt;
      o_Pass        <= done_nxt && (err_nxt == 3'd0);
      o_Fail        <= done_nxt && (err_nxt != 3'd0);
      o_Fail_Vector <= fail_vec_nxt;
      o_Error_Count <= err_nxt;
    end
  end

endmodule : gate_self_tester

// File: tb/tb_gate_self_tester.sv
// Directed self-checking bench for gate_self_tester with SETTLE_CYCLES=4
// and a behavioural AND gate (optionally forced to a constant) on i_Result.
module tb_gate_self_tester;

  logic       i_Clk;
  logic       i_Rst;
  logic       i_Start;
  logic       i_Result;
  logic       o_Stim_1, o_Stim_2;
  logic       o_Busy, o_Done, o_Pass, o_Fail;
  logic [1:0] o_Fail_Vector;
  logic [2:0] o_Error_Count;

  // 0: correct AND gate, 1: output stuck at 1, 2: output stuck at 0
  int result_mode;
  int checks;
  int errors;
  int done_k;

  assign i_Result = (result_mode == 0) ? (o_Stim_1 & o_Stim_2) : (result_mode == 1);

  gate_self_tester #(
    .SETTLE_CYCLES(4),
    .EXPECTED     (4'b1000)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Start      (i_Start),
    .i_Result     (i_Result),
    .o_Stim_1     (o_Stim_1),
    .o_Stim_2     (o_Stim_2),
    .o_Busy       (o_Busy),
    .o_Done       (o_Done),
    .o_Pass       (o_Pass),
    .o_Fail       (o_Fail),
    .o_Fail_Vector(o_Fail_Vector),
    .o_Error_Count(o_Error_Count)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // Pulse start so it is sampled on exactly one edge; returns one step after
  // that edge (cycle 0 of the run).
  task automatic start_run();
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    check("start_busy", o_Busy, 1);
    check("start_done", o_Done, 0);
    check("start_stim", {o_Stim_1, o_Stim_2}, 2'b00);
  endtask

  // Runs cycles 1..40 of a sequence, checking the stim pattern each cycle
  // until done rises. pulse_at (>0) re-asserts start on that cycle.
  task automatic run_until_done(input int pulse_at, output int dk);
    dk = -1;
    for (int k = 1; k <= 40 && dk < 0; k++) begin
      if (k == pulse_at) i_Start = 1'b1;
      step();
      i_Start = 1'b0;
      if (o_Done) begin
        dk = k;
      end else if (k < 20) begin
        check("run_stim", {o_Stim_1, o_Stim_2}, 32'(k / 5));
        check("run_busy", o_Busy, 1);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    result_mode = 0;
    i_Start     = 1'b0;
    i_Rst       = 1'b1;

    // Reset state
    step();
    step();
    check("rst_busy", o_Busy, 0);
    check("rst_done", o_Done, 0);
    check("rst_pass", o_Pass, 0);
    check("rst_fail", o_Fail, 0);
    check("rst_errcnt", o_Error_Count, 0);
    check("rst_failvec", o_Fail_Vector, 0);
    check("rst_stim", {o_Stim_1, o_Stim_2}, 0);
    i_Rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("idle_busy", o_Busy, 0);
    check("idle_done", o_Done, 0);

    // Correct AND gate: pass, done 20 cycles after accept
    result_mode = 0;
    start_run();
    run_until_done(0, done_k);
    check("and_done_cycle", done_k, 20);
    check("and_pass", o_Pass, 1);
    check("and_fail", o_Fail, 0);
    check("and_errcnt", o_Error_Count, 0);
    check("and_failvec", o_Fail_Vector, 0);
    check("and_busy", o_Busy, 0);
    check("and_stim_done", {o_Stim_1, o_Stim_2}, 0);

    // Stuck at 1: vectors 0,1,2 mismatch
    result_mode = 1;
    start_run();
    run_until_done(0, done_k);
    check("s1_done_cycle", done_k, 20);
    check("s1_fail", o_Fail, 1);
    check("s1_pass", o_Pass, 0);
    check("s1_errcnt", o_Error_Count, 3);
    check("s1_failvec", o_Fail_Vector, 0);

    // Stuck at 0: only vector 3 mismatches
    result_mode = 2;
    start_run();
    check("s0_restart_errcnt", o_Error_Count, 0);
    run_until_done(0, done_k);
    check("s0_done_cycle", done_k, 20);
    check("s0_fail", o_Fail, 1);
    check("s0_pass", o_Pass, 0);
    check("s0_errcnt", o_Error_Count, 1);
    check("s0_failvec", o_Fail_Vector, 3);

    // Restart from a failing DONE with a correct gate; also a stray start
    // pulse at cycle 7 that must be ignored.
    result_mode = 0;
    start_run();
    check("rs_errcnt", o_Error_Count, 0);
    check("rs_fail", o_Fail, 0);
    check("rs_failvec", o_Fail_Vector, 0);
    run_until_done(7, done_k);
    check("rs_done_cycle", done_k, 20);
    check("rs_pass", o_Pass, 1);
    check("rs_fail_end", o_Fail, 0);

    // Asynchronous reset mid-run (cycle 12, two errors accumulated)
    result_mode = 1;
    start_run();
    for (int k = 1; k <= 12; k++) step();
    check("mid_errcnt", o_Error_Count, 2);
    check("mid_stim", {o_Stim_1, o_Stim_2}, 2'b10);
    #2;
    i_Rst = 1'b1;
    #1;
    check("arst_busy", o_Busy, 0);
    check("arst_errcnt", o_Error_Count, 0);
    check("arst_stim", {o_Stim_1, o_Stim_2}, 0);
    check("arst_done", o_Done, 0);
    check("arst_fail", o_Fail, 0);
    step();
    step();
    i_Rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("post_rst_busy", o_Busy, 0);
    check("post_rst_done", o_Done, 0);
    check("post_rst_stim", {o_Stim_1, o_Stim_2}, 0);

    // Next start after reset runs normally
    result_mode = 0;
    start_run();
    run_until_done(0, done_k);
    check("final_done_cycle", done_k, 20);
    check("final_pass", o_Pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_gate_self_tester
